// File: rtl/pipeline_control_sequencer.sv
// rtl/pipeline_control_sequencer.sv - control decode, pipelined control bits, halt drain and retire count
module pipeline_control_sequencer #(
   parameter int RETIRE_W     = 16,
   parameter int DRAIN_CYCLES = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [15:0]         instruction_ID,
   input  logic                valid_ID,
   input  logic                stall,
   input  logic                flush,
   output logic [3:0]          opcode,
   output logic [1:0]          ImmSrc,
   output logic                ALUsrc,
   output logic                dir,
   output logic                is_unsigned,
   output logic                jump_EX,
   output logic                branch_EX,
   output logic                MemRead_MEM,
   output logic                MemWrite_MEM,
   output logic                RegWrite_MEM,
   output logic                ResultSrc_MEM,
   output logic                RegWrite_WB,
   output logic                halted,
   output logic [RETIRE_W-1:0] retired
);

   localparam int CNT_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

   typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_HALTED} state_t;

   state_t             state_q;
   logic [CNT_W-1:0]   drain_cnt_q;
   logic               halted_q;

   logic [3:0] op;
   logic       id_active;
   logic       unused_instr_bits;

   logic       dec_reg_write, dec_alu_src, dec_mem_read, dec_mem_write;
   logic       dec_result_src, dec_branch, dec_jump, dec_dir, dec_unsigned;
   logic [1:0] dec_imm_src;

   logic ex_jump_q, ex_branch_q, ex_mem_read_q, ex_mem_write_q;
   logic ex_reg_write_q, ex_result_src_q, ex_valid_q;
   logic wb_reg_write_q, wb_valid_q;
   logic [RETIRE_W-1:0] retired_q;

   assign op                = instruction_ID[15:12];
   assign unused_instr_bits = ^{instruction_ID[11:4], instruction_ID[2:0]};
   // Once a HALT has been accepted nothing younger may reach the datapath.
   assign id_active         = valid_ID && (state_q == S_IDLE);

   always_comb begin
      dec_reg_write  = 1'b0;
      dec_alu_src    = 1'b0;
      dec_mem_read   = 1'b0;
      dec_mem_write  = 1'b0;
      dec_result_src = 1'b0;
      dec_branch     = 1'b0;
      dec_jump       = 1'b0;
      dec_dir        = 1'b0;
      dec_unsigned   = 1'b0;
      dec_imm_src    = 2'b00;
      case (op)
         4'h1, 4'h2, 4'h3, 4'h4, 4'h5: dec_reg_write = 1'b1;
         4'h6: begin
            dec_reg_write = 1'b1;
            dec_dir       = instruction_ID[3];
         end
         4'h7: begin
            dec_reg_write = 1'b1;
            dec_alu_src   = 1'b1;
            dec_imm_src   = 2'b01;
         end
         4'h8: begin
            dec_reg_write  = 1'b1;
            dec_alu_src    = 1'b1;
            dec_mem_read   = 1'b1;
            dec_result_src = 1'b1;
            dec_imm_src    = 2'b01;
         end
         4'h9: begin
            dec_alu_src   = 1'b1;
            dec_mem_write = 1'b1;
            dec_imm_src   = 2'b10;
         end
         4'hA, 4'hB: begin
            dec_branch  = 1'b1;
            dec_imm_src = 2'b11;
         end
         4'hC: begin
            dec_jump    = 1'b1;
            dec_imm_src = 2'b11;
         end
         4'hD: begin
            dec_reg_write = 1'b1;
            dec_unsigned  = 1'b1;
         end
         default: ;
      endcase
   end

   assign opcode      = id_active ? op : 4'h0;
   assign ImmSrc      = id_active ? dec_imm_src : 2'b00;
   assign ALUsrc      = id_active && dec_alu_src;
   assign dir         = id_active && dec_dir;
   assign is_unsigned = id_active && dec_unsigned;

   // Flush and stall both inject an all-zero slot; HALT itself carries no controls and never retires.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_jump_q       <= 1'b0;
         ex_branch_q     <= 1'b0;
         ex_mem_read_q   <= 1'b0;
         ex_mem_write_q  <= 1'b0;
         ex_reg_write_q  <= 1'b0;
         ex_result_src_q <= 1'b0;
         ex_valid_q      <= 1'b0;
      end else if (flush || stall || !id_active) begin
         ex_jump_q       <= 1'b0;
         ex_branch_q     <= 1'b0;
         ex_mem_read_q   <= 1'b0;
         ex_mem_write_q  <= 1'b0;
         ex_reg_write_q  <= 1'b0;
         ex_result_src_q <= 1'b0;
         ex_valid_q      <= 1'b0;
      end else begin
         ex_jump_q       <= dec_jump;
         ex_branch_q     <= dec_branch;
         ex_mem_read_q   <= dec_mem_read;
         ex_mem_write_q  <= dec_mem_write;
         ex_reg_write_q  <= dec_reg_write;
         ex_result_src_q <= dec_result_src;
         ex_valid_q      <= (op != 4'hF);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wb_reg_write_q <= 1'b0;
         wb_valid_q     <= 1'b0;
         retired_q      <= '0;
      end else begin
         wb_reg_write_q <= ex_reg_write_q;
         wb_valid_q     <= ex_valid_q;
         if (wb_valid_q && (state_q != S_HALTED))
            retired_q <= retired_q + RETIRE_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         drain_cnt_q <= '0;
         halted_q    <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (valid_ID && (op == 4'hF) && !stall && !flush) begin
                  state_q     <= S_DRAIN;
                  drain_cnt_q <= CNT_W'(DRAIN_CYCLES);
               end
            end
            S_DRAIN: begin
               // A flush means the HALT sat on a mispredicted path.
               if (flush) begin
                  state_q     <= S_IDLE;
                  drain_cnt_q <= '0;
               end else if (drain_cnt_q <= CNT_W'(1)) begin
                  state_q     <= S_HALTED;
                  drain_cnt_q <= '0;
                  halted_q    <= 1'b1;
               end else begin
                  drain_cnt_q <= drain_cnt_q - CNT_W'(1);
               end
            end
            S_HALTED: ;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign jump_EX       = ex_jump_q;
   assign branch_EX     = ex_branch_q;
   assign MemRead_MEM   = ex_mem_read_q;
   assign MemWrite_MEM  = ex_mem_write_q;
   assign RegWrite_MEM  = ex_reg_write_q;
   assign ResultSrc_MEM = ex_result_src_q;
   assign RegWrite_WB   = wb_reg_write_q;
   assign halted        = halted_q;
   assign retired       = retired_q;

endmodule

// File: doc/pipeline_control_sequencer.md
Name: pipeline_control_sequencer

Overview:
Central control sequencer for the 8-bit, 5-stage pipelined core.
- Decodes the 16-bit instruction in ID and drives the ID-stage controls combinationally.
- Carries per-instruction control bits through the ID/EX and EX/MEM pipeline registers, so every datapath stage sees controls aligned to its own instruction.
- Inserts bubbles on load-use stalls, squashes on mispredict flushes, drains and freezes the pipeline on HALT, and counts retired instructions.

Parameters:
RETIRE_W, 16, width of the retired-instruction counter
DRAIN_CYCLES, 3, cycles after HALT leaves ID before halted asserts

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
instruction_ID  in  16  instruction currently in ID; opcode = [15:12]
valid_ID  in  1  ID instruction is valid (fetch not halted, not flushed)
stall  in  1  load-use stall from hazard detection
flush  in  1  branch mispredict flush from control hazard unit
opcode  out  4  ID-stage opcode to the datapath
ImmSrc  out  2  ID immediate format: 00 R, 01 I (ADDI/LOAD), 10 S (STORE), 11 B/J
ALUsrc  out  1  ID: 1 = immediate operand
dir  out  1  ID: shift direction = instruction_ID[3] for SHIFT, else 0
is_unsigned  out  1  ID: 1 only for SLTU
jump_EX  out  1  EX: unconditional jump in EX
branch_EX  out  1  EX: conditional branch (BEQ/BNE) in EX
MemRead_MEM  out  1  load in EX/MEM slot
MemWrite_MEM  out  1  store in EX/MEM slot
RegWrite_MEM  out  1  register-writing instruction in EX/MEM slot
ResultSrc_MEM  out  1  1 = memory data selected as result
RegWrite_WB  out  1  register write in MEM/WB slot
halted  out  1  pipeline drained after HALT; sticky
retired  out  RETIRE_W  count of instructions reaching WB (bubbles excluded)

Behaviour:
Opcode map, with the control bits each opcode raises:
- 0 NOP: none
- 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR: RegWrite
- 6 SHIFT: RegWrite, dir
- 7 ADDI: RegWrite, ALUsrc
- 8 LOAD: RegWrite, ALUsrc, MemRead, ResultSrc
- 9 STORE: ALUsrc, MemWrite
- A BEQ, B BNE: branch
- C JUMP: jump
- D SLTU: RegWrite, is_unsigned
- E: reserved, treated as NOP
- F HALT: no datapath controls; starts drain

ID-stage decode:
- Outputs are purely combinational from instruction_ID.
- When valid_ID=0 or halt pending, all outputs are 0 (opcode outputs 0).

ID/EX control register (async reset to 0):
- Priority: reset > flush > stall > normal load.
- flush=1: load all zeros (squash).
- stall=1 with flush=0: load zeros (bubble into EX); ID outputs unchanged because the ID instruction is held upstream.
- Otherwise: load the decoded bits.
- jump_EX and branch_EX are driven from this register.
- MemRead_MEM, MemWrite_MEM, RegWrite_MEM and ResultSrc_MEM are also taken from this register. Names follow the datapath port names, so they are valid in the same cycle the instruction is in EX. The hazard unit uses MemRead_MEM as EX-stage MemRead.

EX/MEM register:
- RegWrite_WB is RegWrite_MEM delayed one cycle.
- Ignores stall and flush (always advances).
- Resets to 0.

Retire counter:
- Increments on the cycle RegWrite_WB's slot holds a non-bubble instruction.
- A valid bit travels with the controls; bubbles and squashed slots carry valid=0.
- Wraps modulo 2^RETIRE_W.
- Resets to 0.

Halt FSM (IDLE, DRAIN, HALTED):
- IDLE -> DRAIN when opcode F is in ID with valid_ID=1, stall=0, flush=0. Load drain counter = DRAIN_CYCLES.
- A HALT that is flushed the same cycle is ignored.
- DRAIN: ID controls forced 0. Counter decrements each cycle; at 0 -> HALTED.
- DRAIN: a flush arriving in DRAIN returns to IDLE (the HALT was speculative past a branch).
- HALTED: halted=1, ID/EX loads zeros, retired frozen. Exit only by reset.

Reset mid-operation: all registers, FSM and counter clear asynchronously; outputs 0 in the same cycle.

Test Plan:
1. ADD (0x1xxx) valid, no stall -> RegWrite_MEM=1 at cycle +1, RegWrite_WB=1 at +2, retired=1 at +3.
2. LOAD in EX (MemRead_MEM=1) with stall=1 for one cycle -> next cycle all EX controls 0 (bubble); LOAD reaches RegWrite_WB with ResultSrc_MEM=1 the cycle before; bubble does not increment retired.
3. STORE then flush=1 same cycle -> MemWrite_MEM=0 next cycle; retired unchanged.
4. JUMP (0xCxxx) -> jump_EX=1 exactly one cycle; BNE (0xBxxx) -> branch_EX=1, ImmSrc=11 in ID.
5. SHIFT with instruction[3]=1 -> dir=1; SLTU -> is_unsigned=1; opcode E -> all controls 0.
6. HALT after two ADDs -> halted=1 after DRAIN_CYCLES=3 cycles, retired=2; flush during DRAIN -> FSM back to IDLE, halted stays 0; reset mid-DRAIN -> halted=0, retired=0 immediately.
